apb_timer: RTL
==============

APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 Parameter PRESC_W, default 16, width of the prescaler register and the prescaler counter (legal range 1..32).
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 paddr_i  in  32  APB address; only bits [4:0] decoded.
REQ-005 psel_i / penable_i / pwrite_i  in  1 each  APB select, enable, write.
REQ-006 pwdata_i  in  32  write data; pstrb_i  in  4  byte strobes.
REQ-007 pprot_i  in  3  protection; ignored.
REQ-008 prdata_o  out  32  read data; pready_o  out  1  ready; pslverr_o  out  1  error.
REQ-009 irq_o  out  1  level interrupt, driven directly from flops.

Function
REQ-010 Register map, by offset: 0x00 CTRL (bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN, others read 0); 0x04 PRESCALE [PRESC_W-1:0]; 0x08 COUNT [31:0]; 0x0C CMP [31:0]; 0x10 STATUS (bit0 MATCH, write-1-to-clear).
REQ-011 The APB slave shall be zero-wait: pready_o=1 whenever psel_i&penable_i, else 0.
REQ-012 A write shall commit on the edge where psel_i&penable_i&pwrite_i=1.
- Only byte lanes with pstrb_i set are updated.
- Exactly one commit per access phase.
REQ-013 Read data: prdata_o = addressed register when psel_i&penable_i&!pwrite_i, else 32'h0.
REQ-014 pslverr_o=1 in the access phase when the access is invalid: paddr_i[1:0]!=0, or offset >0x10.
- An invalid write changes no state.
- An invalid read returns 0.
REQ-015 Prescaler: while EN=1, pcnt increments each cycle; when pcnt==PRESCALE, pcnt<=0 and a tick is generated that cycle.
- PRESCALE=0 gives a tick every cycle.
REQ-016 On a tick, with COUNT==CMP:
- MATCH<=1.
- COUNT<=0 if AUTORELOAD=1, else COUNT<=COUNT+1.
REQ-017 On a tick with no match, COUNT<=COUNT+1, wrapping 32'hFFFFFFFF->0.
REQ-018 While EN=0, COUNT, pcnt and MATCH shall hold; no ticks are generated.
REQ-019 A committed write to CTRL with EN=0, or any committed write to PRESCALE, shall clear pcnt.
REQ-020 Simultaneous software write to COUNT and a tick: the written value wins, with no increment applied.
REQ-021 Simultaneous W1C of MATCH and a new match set: set wins, MATCH stays 1.
REQ-022 Write to CMP and a tick in the same cycle: the comparison uses the old CMP value.
REQ-023 irq_o = MATCH & IRQ_EN, registered state only; no combinational path from APB inputs.

Reset
REQ-024 On rst_ni=0, asynchronously set CTRL=0, PRESCALE=0, COUNT=0, CMP=32'hFFFFFFFF, MATCH=0 and pcnt=0.
REQ-025 Output values while in reset: prdata_o=0, pready_o=0, pslverr_o=0, irq_o=0.
REQ-026 Reset asserted mid-transfer shall abort the transfer with no partial register update; the first access after release shall behave normally.

Verification
REQ-027 Write PRESCALE=3, CMP=5, CTRL=0x7 -> COUNT advances once per 4 cycles; MATCH and irq_o rise on the 6th tick; COUNT reads 0 afterwards.
REQ-028 CTRL=0x1 (no autoreload), COUNT=32'hFFFFFFFE, PRESCALE=0, CMP=0 -> COUNT reads FFFFFFFF, then 0, then MATCH=1 on the tick where COUNT==0; irq_o stays 0 (IRQ_EN=0).
REQ-029 Write STATUS=1 in the exact cycle a match tick occurs -> MATCH remains 1; a later W1C with no match clears it; irq_o falls the next cycle.
REQ-030 Read offset 0x14 and write offset 0x06 -> pslverr_o=1 and pready_o=1 in the access phase; prdata_o=0; no register changes.
REQ-031 Write COUNT=0x1234 with pstrb_i=4'b0001 while running at PRESCALE=0 -> only the low byte loads, with the write winning over the tick; the next tick increments from the new value.
REQ-032 Assert rst_ni=0 during the access phase of a CMP write -> CMP reads FFFFFFFF after release; all outputs are 0 during reset.

Source files
------------

// File: rtl/apb_timer.sv
// apb_timer: APB-programmable 32-bit timer with prescaler, compare match and
// level interrupt.
//
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   rst_ni     asynchronous active-low reset
//   paddr_i    APB address, bits [4:0] decoded
//   psel_i     APB select
//   penable_i  APB enable (access phase)
//   pwrite_i   APB write
//   pwdata_i   APB write data
//   pstrb_i    APB byte strobes
//   pprot_i    APB protection (unused)
//   prdata_o   APB read data, 0 outside a valid read access phase
//   pready_o   APB ready, zero-wait
//   pslverr_o  APB error for misaligned or out-of-range offsets
//   irq_o      level interrupt, MATCH & IRQ_EN, from a flop
//
// Register map: 0x00 CTRL {IRQ_EN, AUTORELOAD, EN}, 0x04 PRESCALE,
//               0x08 COUNT, 0x0C CMP, 0x10 STATUS {MATCH, W1C}.
module apb_timer #(
    parameter int unsigned PRESC_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] paddr_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    input  logic [3:0]  pstrb_i,
    input  logic [2:0]  pprot_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic        irq_o
);

    logic [2:0]         ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        cmp_q, cmp_d;
    logic               match_q, match_d;
    logic               irq_q, irq_d;

    logic        access, addr_ok, wr_ok;
    logic        ctrl_wr, presc_wr, count_wr, cmp_wr, status_wr;
    logic [31:0] wmask;
    logic [2:0]  ctrl_new;
    logic        tick, is_match;
    logic [31:0] rdata;

    // Gating with rst_ni keeps every APB output at 0 while in reset.
    assign access  = psel_i & penable_i & rst_ni;
    assign addr_ok = (paddr_i[1:0] == 2'b00) && (paddr_i[4:2] <= 3'd4);
    assign wr_ok   = access & pwrite_i & addr_ok;

    assign ctrl_wr   = wr_ok && (paddr_i[4:2] == 3'd0);
    assign presc_wr  = wr_ok && (paddr_i[4:2] == 3'd1);
    assign count_wr  = wr_ok && (paddr_i[4:2] == 3'd2);
    assign cmp_wr    = wr_ok && (paddr_i[4:2] == 3'd3);
    assign status_wr = wr_ok && (paddr_i[4:2] == 3'd4);

    assign wmask = {{8{pstrb_i[3]}}, {8{pstrb_i[2]}}, {8{pstrb_i[1]}}, {8{pstrb_i[0]}}};

    assign ctrl_new = (ctrl_q & ~wmask[2:0]) | (pwdata_i[2:0] & wmask[2:0]);

    // Tick and match use registered state only, so a same-cycle CMP write
    // compares against the old CMP.
    assign tick     = ctrl_q[0] && (pcnt_q == presc_q);
    assign is_match = tick && (count_q == cmp_q);

    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        cmp_d   = cmp_q;
        count_d = count_q;
        pcnt_d  = pcnt_q;
        match_d = match_q;

        if (ctrl_wr) ctrl_d = ctrl_new;
        if (presc_wr) begin
            presc_d = (presc_q & ~wmask[PRESC_W-1:0]) | (pwdata_i[PRESC_W-1:0] & wmask[PRESC_W-1:0]);
        end
        if (cmp_wr) cmp_d = (cmp_q & ~wmask) | (pwdata_i & wmask);

        // Software clear of the prescaler beats the free-running update.
        if (presc_wr || (ctrl_wr && !ctrl_new[0])) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end else if (ctrl_q[0]) begin
            pcnt_d = pcnt_q + PRESC_W'(1);
        end

        // A COUNT write overrides any tick in the same cycle.
        if (count_wr) begin
            count_d = (count_q & ~wmask) | (pwdata_i & wmask);
        end else if (tick) begin
            count_d = (is_match && ctrl_q[1]) ? '0 : count_q + 32'd1;
        end

        // Setting MATCH takes priority over a concurrent W1C.
        if (is_match) begin
            match_d = 1'b1;
        end else if (status_wr && pstrb_i[0] && pwdata_i[0]) begin
            match_d = 1'b0;
        end
    end

    // irq is registered from the next-state values so it tracks MATCH & IRQ_EN
    // exactly while still coming straight from a flop.
    assign irq_d = match_d & ctrl_d[2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
            count_q <= '0;
            cmp_q   <= '1;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (paddr_i[4:2])
            3'd0:    rdata = {29'd0, ctrl_q};
            3'd1:    rdata = 32'(presc_q);
            3'd2:    rdata = count_q;
            3'd3:    rdata = cmp_q;
            3'd4:    rdata = {31'd0, match_q};
            default: rdata = '0;
        endcase
    end

    assign prdata_o  = (access && !pwrite_i && addr_ok) ? rdata : '0;
    assign pready_o  = access;
    assign pslverr_o = access & ~addr_ok;
    assign irq_o     = irq_q;

    logic unused_ok;
    assign unused_ok = ^{paddr_i[31:5], pprot_i};

endmodule
